// File: rtl/led_frame_sequencer.sv
// One LED-strip refresh: walks current_led through screen_manager, registers each GRB word,
// hands it to the WS2812 serializer, waits for drain, then holds the latch gap.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for enable; current_led holds last value
// ADDR    | settle cycle; colour lookup for current_led is captured at end
// PRESENT | pixel_valid high, word held until serializer accepts it
// DRAIN   | last pixel accepted, waiting for serializer to go idle
// LATCH   | line held low for LATCH_CYCLES, then frame_done pulse
`timescale 1ns/1ps

module led_frame_sequencer #(
   parameter  int MAX_POS      = 109,
   parameter  int LATCH_CYCLES = 14000,
   localparam int LED_W        = (MAX_POS > 1) ? $clog2(MAX_POS) : 1,
   localparam int CNT_W        = $clog2(LATCH_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [7:0]       led_green_intensity,
   input  logic [7:0]       led_red_intensity,
   input  logic [7:0]       led_blue_intensity,
   input  logic             pixel_ready,
   input  logic             ser_idle,
   output logic [LED_W-1:0] current_led,
   output logic [23:0]      pixel_data,
   output logic             pixel_valid,
   output logic             frame_active,
   output logic             frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_PRESENT,
      S_DRAIN,
      S_LATCH
   } state_t;

   localparam logic [LED_W-1:0] LAST_LED = LED_W'(MAX_POS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATCH_CYCLES - 1);

   state_t           r_state;
   logic [LED_W-1:0] r_led;
   logic [23:0]      r_pixel;
   logic             r_valid;
   logic             r_active;
   logic             r_done;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_led    <= '0;
         r_pixel  <= '0;
         r_valid  <= 1'b0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_led    <= '0;
                  r_active <= 1'b1;
                  r_state  <= S_ADDR;
               end
            end
            S_ADDR: begin
               r_pixel <= {led_green_intensity, led_red_intensity, led_blue_intensity};
               r_valid <= 1'b1;
               r_state <= S_PRESENT;
            end
            S_PRESENT: begin
               if (r_valid && pixel_ready) begin
                  r_valid <= 1'b0;
                  if (r_led == LAST_LED) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_led   <= r_led + 1'b1;
                     r_state <= S_ADDR;
                  end
               end
            end
            S_DRAIN: begin
               if (ser_idle) begin
                  r_cnt   <= '0;
                  r_state <= S_LATCH;
               end
            end
            S_LATCH: begin
               // counter parks on its last value; it is cleared on the next DRAIN exit
               if (r_cnt == CNT_LAST) begin
                  r_done   <= 1'b1;
                  r_active <= 1'b0;
                  r_state  <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign current_led  = r_led;
   assign pixel_data   = r_pixel;
   assign pixel_valid  = r_valid;
   assign frame_active = r_active;
   assign frame_done   = r_done;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer (4 LEDs, 5-cycle latch) with a pixel scoreboard.
`timescale 1ns/1ps

module tb_led_frame_sequencer;
   localparam int NP = 4;
   localparam int NL = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b0;
   logic        pixel_ready = 1'b0;
   logic        ser_idle = 1'b1;
   logic [1:0]  current_led;
   logic [7:0]  g_int, r_int, b_int;
   logic [23:0] pixel_data;
   logic        pixel_valid, frame_active, frame_done;

   typedef struct packed {
      logic [1:0]  led;
      logic [23:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_e;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // screen_manager stand-in: colour is a simple function of the LED index
   assign g_int = 8'h11 + {6'b0, current_led};
   assign r_int = 8'h33 + {6'b0, current_led};
   assign b_int = 8'h55 + {6'b0, current_led};

   led_frame_sequencer #(.MAX_POS(NP), .LATCH_CYCLES(NL)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .enable              (enable),
      .led_green_intensity (g_int),
      .led_red_intensity   (r_int),
      .led_blue_intensity  (b_int),
      .pixel_ready         (pixel_ready),
      .ser_idle            (ser_idle),
      .current_led         (current_led),
      .pixel_data          (pixel_data),
      .pixel_valid         (pixel_valid),
      .frame_active        (frame_active),
      .frame_done          (frame_done)
   );

   function automatic logic [23:0] colour(input int led);
      logic [7:0] l;
      l = 8'(led);
      return {8'h11 + l, 8'h33 + l, 8'h55 + l};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame();
      for (int i = 0; i < NP; i++) sb_q.push_back('{led: 2'(i), data: colour(i)});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: a pixel is taken on the edge following a negedge that shows valid && ready
   always @(negedge clk) begin
      if (rst_n && pixel_valid && pixel_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_pixel", 32'(sb_q.size()), 1);
         end else begin
            sb_e = sb_q.pop_front();
            chk("sb_data", {8'h0, pixel_data}, {8'h0, sb_e.data});
            chk("sb_led", {30'h0, current_led}, {30'h0, sb_e.led});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  done_k;
      int  done_cnt;
      int  active_after;
      bit  found;

      // reset
      #1 rst_n = 1'b0;
      #2;
      chk("rst_led", {30'h0, current_led}, 0);
      chk("rst_data", {8'h0, pixel_data}, 0);
      chk("rst_valid", {31'h0, pixel_valid}, 0);
      chk("rst_active", {31'h0, frame_active}, 0);
      chk("rst_done", {31'h0, frame_done}, 0);
      step();
      step();
      rst_n = 1'b1;

      // 1: free-running frame timing
      enable = 1'b1; pixel_ready = 1'b1; ser_idle = 1'b1;
      push_frame();
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("t1_led_seq", {30'h0, current_led}, (k - 1) / 2);
         if (k == 1) chk("t1_active", {31'h0, frame_active}, 1);
      end
      found = 0; done_k = 0;
      for (int k = 9; k <= 40 && !found; k++) begin
         step();
         if (frame_done) begin found = 1; done_k = k; end
      end
      chk("t1_done_seen", {31'h0, found}, 1);
      chk("t1_frame_len", done_k - 1, 2 * NP + 1 + NL);
      chk("t1_all_pixels", sb_q.size(), 0);
      push_frame();
      step();
      chk("t1_restart_active", {31'h0, frame_active}, 1);
      chk("t1_restart_led", {30'h0, current_led}, 0);
      chk("t1_restart_done", {31'h0, frame_done}, 0);

      // 3: colour capture on LED 1
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (pixel_valid && current_led == 2'd1) found = 1;
      end
      chk("t3_led1_found", {31'h0, found}, 1);
      chk("t3_pixel", {8'h0, pixel_data}, 32'h123456);

      // 2: backpressure on LED 2
      step();
      pixel_ready = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         chk("t2_valid", {31'h0, pixel_valid}, 1);
         chk("t2_led", {30'h0, current_led}, 2);
         chk("t2_data", {8'h0, pixel_data}, {8'h0, colour(2)});
      end
      pixel_ready = 1'b1;
      ser_idle = 1'b0;
      step();
      chk("t2_advance_led", {30'h0, current_led}, 3);
      chk("t2_advance_valid", {31'h0, pixel_valid}, 0);

      // 4: drain holds off the latch
      step();
      step();
      chk("t4_drain_led", {30'h0, current_led}, 3);
      chk("t4_drain_valid", {31'h0, pixel_valid}, 0);
      done_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (frame_done || !frame_active) done_cnt++;
      end
      chk("t4_no_latch_early", done_cnt, 0);
      ser_idle = 1'b1;
      found = 0; done_k = 0;
      for (int k = 1; k <= NL + 10 && !found; k++) begin
         step();
         if (frame_done) begin found = 1; done_k = k; end
      end
      chk("t4_done_seen", {31'h0, found}, 1);
      chk("t4_latch_len", done_k - 1, NL);
      chk("t4_all_pixels", sb_q.size(), 0);
      push_frame();

      // 5: enable dropped mid-frame
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (current_led == 2'd1) found = 1;
      end
      chk("t5_led1_found", {31'h0, found}, 1);
      enable = 1'b0;
      done_cnt = 0; active_after = 0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (frame_done) done_cnt++;
         if (done_cnt > 0 && frame_active) active_after++;
      end
      chk("t5_single_done", done_cnt, 1);
      chk("t5_stays_idle", active_after, 0);
      chk("t5_all_pixels", sb_q.size(), 0);

      // 6a: reset while presenting
      enable = 1'b1;
      push_frame();
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (pixel_valid && current_led == 2'd1) found = 1;
      end
      chk("t6_present_found", {31'h0, found}, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6p_valid", {31'h0, pixel_valid}, 0);
      chk("t6p_led", {30'h0, current_led}, 0);
      chk("t6p_data", {8'h0, pixel_data}, 0);
      chk("t6p_active", {31'h0, frame_active}, 0);
      sb_q.delete();
      step();
      step();
      push_frame();
      rst_n = 1'b1;
      step();
      chk("t6p_restart_active", {31'h0, frame_active}, 1);
      chk("t6p_restart_led", {30'h0, current_led}, 0);

      // 6b: reset during the latch gap
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (sb_q.size() == 0) found = 1;
      end
      chk("t6_drained", {31'h0, found}, 1);
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("t6l_active", {31'h0, frame_active}, 0);
      chk("t6l_led", {30'h0, current_led}, 0);
      chk("t6l_done", {31'h0, frame_done}, 0);
      step();
      push_frame();
      rst_n = 1'b1;
      found = 0; done_k = 0;
      for (int k = 1; k <= 40 && !found; k++) begin
         step();
         if (k == 1) chk("t6l_restart_led", {30'h0, current_led}, 0);
         if (frame_done) begin found = 1; done_k = k; end
      end
      chk("t6l_done_seen", {31'h0, found}, 1);
      chk("t6l_frame_len", done_k - 1, 2 * NP + 1 + NL);
      chk("t6l_all_pixels", sb_q.size(), 0);
      enable = 1'b0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
